icache_direct_mapped: RTL

- Direct-mapped, read-only instruction cache between the fetch stage and the zero-latency instruction memory.
- Serves fetch hits in the same cycle.
- On a miss it stalls fetch and refills one whole line from instruction memory, one word per cycle.
- Supports full invalidation (fence.i) and keeps saturating hit and miss counters for performance runs.

---
 rtl/icache_direct_mapped.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache.
// Hits are answered combinationally in the request cycle; a miss stalls fetch
// and refills the whole line one word per cycle from zero-latency memory.
// A flush clears every valid bit; a flush seen mid-refill is remembered and
// applied when the refill finishes, so the freshly filled line is dropped too.
module icache_direct_mapped #(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [31:0]           resp_instr,
  output logic                  stall,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_data,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int WSEL_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF    = WSEL_W + 2;
  localparam int TAG_W  = ADDR_WIDTH - OFF - IDX_W;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t state_r, state_nxt_s;

  logic [NUM_LINES-1:0] valid_r;
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [31:0]          data_r [NUM_LINES][WORDS_PER_LINE];

  logic [WSEL_W-1:0] cnt_r;
  logic [IDX_W-1:0]  refill_idx_r;
  logic [TAG_W-1:0]  refill_tag_r;
  logic              flush_pending_r;
  logic [31:0]       hit_count_r;
  logic [31:0]       miss_count_r;

  logic [WSEL_W-1:0]     req_wsel_s;
  logic [IDX_W-1:0]      req_idx_s;
  logic [TAG_W-1:0]      req_tag_s;
  logic                  hit_s;
  logic                  refill_last_s;
  logic                  count_hit_s;
  logic                  count_miss_s;
  logic                  resp_valid_s;
  logic [31:0]           resp_instr_s;
  logic                  stall_s;
  logic                  mem_rd_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic                  unused_addr_bits_s;

  assign req_wsel_s         = req_addr[OFF-1:2];
  assign req_idx_s          = req_addr[OFF+IDX_W-1:OFF];
  assign req_tag_s          = req_addr[ADDR_WIDTH-1:OFF+IDX_W];
  assign unused_addr_bits_s = ^req_addr[1:0];

  // flush wins over a lookup so a request in the flush cycle always refills
  assign hit_s = req_valid & valid_r[req_idx_s] & (tag_r[req_idx_s] == req_tag_s) & ~flush;
  assign refill_last_s = (state_r == REFILL) && (cnt_r == WSEL_W'(WORDS_PER_LINE - 1));

  // Next-state decode and the combinational fetch/memory-side outputs
  always_comb begin
    state_nxt_s  = state_r;
    resp_valid_s = 1'b0;
    resp_instr_s = 32'd0;
    stall_s      = 1'b0;
    mem_rd_s     = 1'b0;
    mem_addr_s   = {ADDR_WIDTH{1'b0}};
    count_hit_s  = 1'b0;
    count_miss_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (hit_s) begin
          resp_valid_s = 1'b1;
          resp_instr_s = data_r[req_idx_s][req_wsel_s];
          count_hit_s  = 1'b1;
        end else if (req_valid) begin
          stall_s      = 1'b1;
          count_miss_s = 1'b1;
          state_nxt_s  = REFILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REFILL: begin
        stall_s    = 1'b1;
        mem_rd_s   = 1'b1;
        mem_addr_s = {refill_tag_r, refill_idx_r, cnt_r, 2'b00};
        if (refill_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REFILL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Outputs stay quiet while reset is held, even if fetch keeps a request up
  assign resp_valid = resp_valid_s & rst_n;
  assign resp_instr = rst_n ? resp_instr_s : 32'd0;
  assign stall      = stall_s & rst_n;
  assign mem_rd     = mem_rd_s & rst_n;
  assign mem_addr   = rst_n ? mem_addr_s : {ADDR_WIDTH{1'b0}};
  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

  // Control state: FSM, refill bookkeeping, valid bits and pending flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      cnt_r           <= {WSEL_W{1'b0}};
      refill_idx_r    <= {IDX_W{1'b0}};
      refill_tag_r    <= {TAG_W{1'b0}};
      flush_pending_r <= 1'b0;
      valid_r         <= {NUM_LINES{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (flush) begin
            valid_r <= {NUM_LINES{1'b0}};
          end
          if (count_miss_s) begin
            refill_idx_r <= req_idx_s;
            refill_tag_r <= req_tag_s;
            cnt_r        <= {WSEL_W{1'b0}};
          end
        end
        REFILL: begin
          cnt_r <= cnt_r + WSEL_W'(1);
          if (refill_last_s) begin
            if (flush_pending_r || flush) begin
              valid_r <= {NUM_LINES{1'b0}};
            end else begin
              valid_r[refill_idx_r] <= 1'b1;
            end
            flush_pending_r <= 1'b0;
          end else if (flush) begin
            flush_pending_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays: written only during refill, never reset
  always_ff @(posedge clk) begin
    if (state_r == REFILL) begin
      data_r[refill_idx_r][cnt_r] <= mem_data;
      if (refill_last_s) begin
        tag_r[refill_idx_r] <= refill_tag_r;
      end
    end
  end

  // Saturating performance counters, advanced only by IDLE lookups
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      if (count_hit_s && (hit_count_r != 32'hFFFF_FFFF)) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if (count_miss_s && (miss_count_r != 32'hFFFF_FFFF)) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

endmodule
